efp_lut_server: RTL and testbench

// - Responder side of the EFP conversion-lookup interface used by the complex adders (addra out, result_bin back).
// - Captures one batch of N_REQ table addresses (real/imag pairs) and reads them from a loadable table,
//   two per cycle. Returns all results together with a one-cycle valid strobe.
// - Sits beside each 2x2 complex matrix adder and replaces per-adder ROMs with one shared, reloadable table.

---
 rtl/efp_lut_pkg.sv | 18 +
 rtl/efp_lut_bram.sv | 35 +++
 rtl/efp_lut_server.sv | 173 +++++++++++++++++
 tb/tb_efp_lut_server.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/efp_lut_pkg.sv
// Shared types and default geometry for the EFP conversion-lookup server.
package efp_lut_pkg;

  localparam int unsigned LutAddrW = 11;
  localparam int unsigned LutDataW = 11;
  localparam int unsigned LutNReq  = 8;
  localparam int unsigned LutDepth = 2048;

  typedef logic [LutAddrW-1:0] lut_addr_t;
  typedef logic [LutDataW-1:0] lut_data_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StResp
  } state_t;

endpackage

// File: rtl/efp_lut_bram.sv
// Single-write, single registered read-first port table of DEPTH words.
module efp_lut_bram #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 11,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              w_in_range;
  logic              r_in_range;

  assign w_in_range = {1'b0, waddr_i} < DepthLim;
  assign r_in_range = {1'b0, raddr_i} < DepthLim;

  // Unpopulated addresses read as zero and swallow writes.
  always_ff @(posedge clk_i) begin
    if (we_i && w_in_range) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= r_in_range ? mem_q[raddr_i] : '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/efp_lut_server.sv
// Shared reloadable lookup table serving a batch of N_REQ addresses two per cycle,
// returning every result at once with a single-cycle rsp_valid strobe.
module efp_lut_server
  import efp_lut_pkg::*;
#(
  parameter int unsigned ADDR_W = LutAddrW,
  parameter int unsigned DATA_W = LutDataW,
  parameter int unsigned N_REQ  = LutNReq,
  parameter int unsigned DEPTH  = LutDepth
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [N_REQ*ADDR_W-1:0] addra,
  output logic                    busy,
  output logic                    rsp_valid,
  output logic [N_REQ*DATA_W-1:0] result_bin,
  output logic                    addr_err,
  output logic                    req_drop,
  input  logic                    tbl_we,
  input  logic [ADDR_W-1:0]       tbl_waddr,
  input  logic [DATA_W-1:0]       tbl_wdata
);

  localparam int unsigned     NPair    = N_REQ / 2;
  localparam int unsigned     CntW     = (NPair > 1) ? $clog2(NPair) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(NPair - 1);
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  state_t                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q  [N_REQ];
  logic [DATA_W-1:0]       stage_q [N_REQ];
  logic [DATA_W-1:0]       stage_d [N_REQ];
  logic [N_REQ*DATA_W-1:0] result_q, result_d;
  logic                    rsp_valid_q, addr_err_q, req_drop_q, err_q;
  logic                    rd_pend_q;
  logic [CntW-1:0]         rd_idx_q;

  logic              accept, drop;
  logic [CntW:0]     idx_re, idx_im;
  logic [ADDR_W-1:0] rd_addr_re, rd_addr_im;
  logic [DATA_W-1:0] rd_data_re, rd_data_im;
  logic              oor_re, oor_im;

  assign idx_re     = {cnt_q, 1'b0};
  assign idx_im     = {cnt_q, 1'b1};
  assign rd_addr_re = addr_q[idx_re];
  assign rd_addr_im = addr_q[idx_im];
  assign oor_re     = {1'b0, rd_addr_re} >= DepthLim;
  assign oor_im     = {1'b0, rd_addr_im} >= DepthLim;

  // Two replicated tables sharing the write port give two reads per cycle.
  efp_lut_bram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bram_re (
    .clk_i   (clk),
    .we_i    (tbl_we),
    .waddr_i (tbl_waddr),
    .wdata_i (tbl_wdata),
    .raddr_i (rd_addr_re),
    .rdata_o (rd_data_re)
  );

  efp_lut_bram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bram_im (
    .clk_i   (clk),
    .we_i    (tbl_we),
    .waddr_i (tbl_waddr),
    .wdata_i (tbl_wdata),
    .raddr_i (rd_addr_im),
    .rdata_o (rd_data_im)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        drop = req_valid;
        if (cnt_q == CntLast) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = StRead;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The pair landing this cycle is merged here so RESP publishes it in the same edge.
  always_comb begin
    stage_d = stage_q;
    if (rd_pend_q) begin
      stage_d[{rd_idx_q, 1'b0}] = rd_data_re;
      stage_d[{rd_idx_q, 1'b1}] = rd_data_im;
    end
    result_d = '0;
    for (int k = 0; k < N_REQ; k++) begin
      result_d[k*DATA_W +: DATA_W] = stage_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '{default: '0};
      stage_q     <= '{default: '0};
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      req_drop_q  <= 1'b0;
      err_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rd_pend_q <= (state_q == StRead);
      rd_idx_q  <= cnt_q;
      if (accept) begin
        for (int k = 0; k < N_REQ; k++) begin
          addr_q[k] <= addra[k*ADDR_W +: ADDR_W];
        end
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if ((state_q == StRead) && (oor_re || oor_im)) begin
        err_q <= 1'b1;
      end
      rsp_valid_q <= (state_q == StResp);
      addr_err_q  <= (state_q == StResp) && err_q;
      if (state_q == StResp) begin
        result_q <= result_d;
      end
      if (drop) begin
        req_drop_q <= 1'b1;
      end
    end
  end

  assign busy       = (state_q == StRead);
  assign rsp_valid  = rsp_valid_q;
  assign result_bin = result_q;
  assign addr_err   = addr_err_q;
  assign req_drop   = req_drop_q;

endmodule

// File: tb/tb_efp_lut_server.sv
// Scoreboard bench: two servers (full and 1500-entry table) share all stimulus.
module tb_efp_lut_server;

  localparam int unsigned AW         = 11;
  localparam int unsigned DW         = 11;
  localparam int unsigned NR         = 8;
  localparam int unsigned BigDepth   = 2048;
  localparam int unsigned SmallDepth = 1500;

  typedef struct packed {
    logic [NR*DW-1:0] data;
    logic             err;
    logic [31:0]      due;
  } exp_t;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              req_valid = 1'b0;
  logic [NR*AW-1:0]  addra     = '0;
  logic              tbl_we    = 1'b0;
  logic [AW-1:0]     tbl_waddr = '0;
  logic [DW-1:0]     tbl_wdata = '0;

  logic [1:0]        busy, rsp_valid, addr_err, req_drop;
  logic [NR*DW-1:0]  result_bin [2];

  exp_t              exp_q [2][$];
  logic [DW-1:0]     tbl_m [BigDepth];
  logic [NR*DW-1:0]  held  [2];
  logic              exp_drop = 1'b0;
  int unsigned       cyc      = 0;
  int                n_checks = 0;
  int                n_pass   = 0;

  efp_lut_server #(
    .ADDR_W (AW), .DATA_W (DW), .N_REQ (NR), .DEPTH (BigDepth)
  ) u_dut_big (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .addra      (addra),
    .busy       (busy[0]),
    .rsp_valid  (rsp_valid[0]),
    .result_bin (result_bin[0]),
    .addr_err   (addr_err[0]),
    .req_drop   (req_drop[0]),
    .tbl_we     (tbl_we),
    .tbl_waddr  (tbl_waddr),
    .tbl_wdata  (tbl_wdata)
  );

  efp_lut_server #(
    .ADDR_W (AW), .DATA_W (DW), .N_REQ (NR), .DEPTH (SmallDepth)
  ) u_dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .addra      (addra),
    .busy       (busy[1]),
    .rsp_valid  (rsp_valid[1]),
    .result_bin (result_bin[1]),
    .addr_err   (addr_err[1]),
    .req_drop   (req_drop[1]),
    .tbl_we     (tbl_we),
    .tbl_waddr  (tbl_waddr),
    .tbl_wdata  (tbl_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Every slot is a plain table lookup; unpopulated slots read zero and flag the batch.
  function automatic exp_t model(input logic [NR*AW-1:0] av, input int unsigned depth);
    exp_t        e;
    int unsigned a;
    e = '0;
    for (int k = 0; k < NR; k++) begin
      a = av[k*AW +: AW];
      if (a >= depth) e.err = 1'b1;
      else e.data[k*DW +: DW] = tbl_m[a];
    end
    e.due = cyc + 5;
    return e;
  endfunction

  function automatic logic [NR*AW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int               a [NR];
    logic [NR*AW-1:0] v;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int k = 0; k < NR; k++) v[k*AW +: AW] = AW'(a[k]);
    return v;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Caller guarantees the server is idle or in its response cycle.
  task automatic send_batch(input logic [NR*AW-1:0] av);
    req_valid = 1'b1;
    addra     = av;
    wait_cyc(1);
    req_valid = 1'b0;
    exp_q[0].push_back(model(av, BigDepth));
    exp_q[1].push_back(model(av, SmallDepth));
  endtask

  task automatic tbl_write(input int unsigned a, input logic [DW-1:0] d);
    tbl_we    = 1'b1;
    tbl_waddr = AW'(a);
    tbl_wdata = d;
    wait_cyc(1);
    tbl_we   = 1'b0;
    tbl_m[a] = d;
  endtask

  task automatic mon(input int d);
    exp_t e;
    logic busy_exp;
    busy_exp = 1'b0;
    for (int i = 0; i < exp_q[d].size(); i++) begin
      if (exp_q[d][i].due >= cyc + 2 && exp_q[d][i].due <= cyc + 5) busy_exp = 1'b1;
    end
    check($sformatf("busy[dut%0d]", d), busy[d], busy_exp);
    if (exp_q[d].size() != 0 && exp_q[d][0].due < cyc) begin
      n_checks++;
      $display("FAIL rsp_timeout[dut%0d]: no rsp_valid by cycle %0d, required at %0d",
               d, cyc, exp_q[d][0].due);
      e = exp_q[d].pop_front();
    end
    if (rsp_valid[d]) begin
      if (exp_q[d].size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp[dut%0d]: rsp_valid=1 with nothing outstanding (cycle %0d)",
                 d, cyc);
      end else begin
        e = exp_q[d].pop_front();
        check($sformatf("rsp_cycle[dut%0d]", d), cyc, e.due);
        check($sformatf("result_bin[dut%0d]", d), result_bin[d], e.data);
        check($sformatf("addr_err[dut%0d]", d), addr_err[d], e.err);
      end
      held[d] = result_bin[d];
    end else begin
      check($sformatf("result_hold[dut%0d]", d), result_bin[d], held[d]);
      check($sformatf("addr_err_idle[dut%0d]", d), addr_err[d], 1'b0);
    end
    check($sformatf("req_drop[dut%0d]", d), req_drop[d], exp_drop);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    logic [NR*AW-1:0] av;
    held[0] = '0;
    held[1] = '0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(1);

    for (int i = 0; i < int'(BigDepth); i++) tbl_write(i, DW'(i) ^ 11'h7FF);
    wait_cyc(2);

    // Basic batch, then a second one accepted in the response cycle.
    send_batch(pk(0, 1, 2, 3, 100, 200, 1023, 2047));
    wait_cyc(4);
    send_batch(pk(7, 8, 9, 10, 11, 12, 13, 14));
    wait_cyc(8);

    // A request during READ is dropped and latches req_drop.
    send_batch(pk(20, 21, 22, 23, 24, 25, 26, 27));
    wait_cyc(1);
    req_valid = 1'b1;
    addra     = pk(1, 1, 1, 1, 1, 1, 1, 1);
    wait_cyc(1);
    req_valid = 1'b0;
    exp_drop  = 1'b1;
    wait_cyc(8);

    // Write to address 5 while pair 0 reads it: old data, then new data next batch.
    send_batch(pk(5, 6, 30, 31, 32, 33, 34, 35));
    tbl_write(5, 11'h123);
    wait_cyc(8);
    send_batch(pk(5, 5, 6, 7, 1499, 1500, 2046, 0));
    wait_cyc(8);

    send_batch(pk(10, 20, 30, 1600, 40, 50, 1499, 1500));
    wait_cyc(8);

    // Reset two cycles into READ aborts the batch.
    send_batch(pk(60, 61, 62, 63, 64, 65, 66, 67));
    wait_cyc(2);
    rst_n = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    held[0]  = '0;
    held[1]  = '0;
    exp_drop = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    send_batch(pk(70, 71, 72, 73, 1700, 75, 76, 77));
    wait_cyc(8);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < int'(NR); k++) av[k*AW +: AW] = AW'($urandom_range(0, BigDepth - 1));
      send_batch(av);
      if ($urandom_range(0, 2) == 0) begin
        wait_cyc(4);
      end else begin
        wait_cyc(5);
        repeat ($urandom_range(0, 3)) tbl_write($urandom_range(0, BigDepth - 1), DW'($urandom));
        wait_cyc($urandom_range(0, 2));
      end
    end
    wait_cyc(10);

    check("drain[dut0]", exp_q[0].size(), 0);
    check("drain[dut1]", exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
